// File: rtl/data_receiver.sv
// -----------------------------------------------------------------------------
// data_receiver
//
// SPI slave receive path. Samples mosi on each SCL rising-edge pulse supplied
// by the upstream edge detector while chip-select (en_i) is asserted. Bits are
// assembled into DATA_WIDTH-bit words. Each completed word is presented on
// data_o together with a one-cycle data_valid_o strobe. A frame that ends with
// a partial word sets the sticky frame_error_o flag.
//
// Optional build macro: SPI_RX_MOSI_SYNC_EN
//   defined   : mosi_i passes through a 2-flop synchroniser before sampling
//   undefined : mosi_i is sampled directly (it must already be synchronous)
//
// Ports:
//   clk_i                   in   system clock, all logic on posedge
//   reset_i                 in   synchronous active-high reset
//   en_i                    in   slave enable (CS, already synchronised)
//   scl_pos_edge_detected_i in   one-cycle pulse per SCL rising edge
//   mosi_i                  in   serial data from master
//   data_o                  out  last completed word
//   data_valid_o            out  one-cycle strobe, data_o updated this cycle
//   byte_cnt_o              out  words completed in current frame (wraps)
//   frame_error_o           out  sticky: frame ended with a partial word
// -----------------------------------------------------------------------------
module data_receiver #(
   parameter int DATA_WIDTH     = 8,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int BYTE_CNT_WIDTH = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      en_i,
   input  logic                      scl_pos_edge_detected_i,
   input  logic                      mosi_i,
   output logic [DATA_WIDTH-1:0]     data_o,
   output logic                      data_valid_o,
   output logic [BYTE_CNT_WIDTH-1:0] byte_cnt_o,
   output logic                      frame_error_o
);

   // Bit counter counts down from DATA_WIDTH to 1; it needs to hold DATA_WIDTH.
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   logic                      r_en_q;
   logic [CNT_W-1:0]          r_bit_cnt;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [DATA_WIDTH-1:0]     r_data;
   logic                      r_data_valid;
   logic [BYTE_CNT_WIDTH-1:0] r_byte_cnt;
   logic                      r_frame_err;

   logic                      w_mosi_s;
   logic                      w_rise;
   logic [DATA_WIDTH-1:0]     w_shift_next;

`ifdef SPI_RX_MOSI_SYNC_EN
   logic r_mosi_meta;
   logic r_mosi_sync;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_mosi_meta <= mosi_i;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   assign w_mosi_s = r_mosi_sync;
`else
   assign w_mosi_s = mosi_i;
`endif

   assign w_rise = en_i & ~r_en_q;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_mosi_s};
      end else begin : g_lsb_first
         assign w_shift_next = {w_mosi_s, r_shift[DATA_WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_en_q       <= 1'b0;
         r_bit_cnt    <= CNT_FULL;
         r_shift      <= '0;
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_byte_cnt   <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_en_q       <= en_i;
         r_data_valid <= 1'b0;
         if (w_rise) begin
            // New frame. A pulse coinciding with the CS rise is ignored.
            r_byte_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_bit_cnt   <= CNT_FULL;
            r_shift     <= '0;
         end else if (!en_i) begin
            // On the CS fall the counter still reflects the pre-pulse state,
            // so a same-cycle SCL pulse never masks a partial word.
            if (r_en_q && (r_bit_cnt != CNT_FULL)) begin
               r_frame_err <= 1'b1;
            end
            r_bit_cnt <= CNT_FULL;
            r_shift   <= '0;
         end else if (scl_pos_edge_detected_i) begin
            if (r_bit_cnt == CNT_LAST) begin
               r_data       <= w_shift_next;
               r_data_valid <= 1'b1;
               r_byte_cnt   <= r_byte_cnt + 1'b1;
               r_bit_cnt    <= CNT_FULL;
               r_shift      <= '0;
            end else begin
               r_shift   <= w_shift_next;
               r_bit_cnt <= r_bit_cnt - 1'b1;
            end
         end
      end
   end

   assign data_o        = r_data;
   assign data_valid_o  = r_data_valid;
   assign byte_cnt_o    = r_byte_cnt;
   assign frame_error_o = r_frame_err;

endmodule

// File: tb/tb_data_receiver.sv
// Bench for data_receiver: directed scenarios plus a randomized run, with one
// MSB-first and one LSB-first instance driven by the same stimulus. Expected
// values come from the scenario constants and from a bit-queue reference model.
module tb_data_receiver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b0;
   logic         scl = 1'b0;
   logic         mosi = 1'b0;

   logic [W-1:0] data_msb, data_lsb;
   logic         dv_msb, dv_lsb;
   logic [3:0]   cnt_msb, cnt_lsb;
   logic         err_msb, err_lsb;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit           q_bits[$];
   logic [W-1:0] m_word_msb = '0;
   logic [W-1:0] m_word_lsb = '0;
   logic         m_valid = 1'b0;
   int           m_cnt = 0;
   logic         m_err = 1'b0;
   logic         m_prev_en = 1'b0;

   always #5 clk = ~clk;

   data_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b1), .BYTE_CNT_WIDTH(4)) dut_msb (
      .clk_i(clk), .reset_i(reset), .en_i(en), .scl_pos_edge_detected_i(scl),
      .mosi_i(mosi), .data_o(data_msb), .data_valid_o(dv_msb),
      .byte_cnt_o(cnt_msb), .frame_error_o(err_msb)
   );

   data_receiver #(.DATA_WIDTH(W), .MSB_FIRST(1'b0), .BYTE_CNT_WIDTH(4)) dut_lsb (
      .clk_i(clk), .reset_i(reset), .en_i(en), .scl_pos_edge_detected_i(scl),
      .mosi_i(mosi), .data_o(data_lsb), .data_valid_o(dv_lsb),
      .byte_cnt_o(cnt_lsb), .frame_error_o(err_lsb)
   );

   // Frame-level model: collected bits form a word once W of them arrived.
   task automatic model_step(input logic r, input logic e, input logic s, input logic m);
      if (r) begin
         q_bits.delete();
         m_word_msb = '0;
         m_word_lsb = '0;
         m_valid    = 1'b0;
         m_cnt      = 0;
         m_err      = 1'b0;
         m_prev_en  = 1'b0;
         return;
      end
      m_valid = 1'b0;
      if (e && !m_prev_en) begin
         q_bits.delete();
         m_cnt = 0;
         m_err = 1'b0;
      end else if (!e) begin
         if (m_prev_en && q_bits.size() != 0) m_err = 1'b1;
         q_bits.delete();
      end else if (s) begin
         q_bits.push_back(m);
         if (q_bits.size() == W) begin
            m_word_msb = '0;
            m_word_lsb = '0;
            foreach (q_bits[k]) begin
               m_word_msb = (m_word_msb << 1) | W'(q_bits[k]);
               m_word_lsb = m_word_lsb + (q_bits[k] ? (W'(1) << k) : W'(0));
            end
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % 16;
            q_bits.delete();
         end
      end
      m_prev_en = e;
   endtask

   // Apply one clock of inputs; returns 1 time unit after the edge.
   task automatic cycle(input logic r, input logic e, input logic s, input logic m);
      reset = r; en = e; scl = s; mosi = m;
      @(posedge clk);
      model_step(r, e, s, m);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      n_cmp++; if (data_msb !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_msb); end
      n_cmp++; if (dv_msb !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dv_msb); end
      n_cmp++; if (cnt_msb !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_msb); end
      n_cmp++; if (err_msb !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_msb); end
      n_cmp++; if (data_lsb !== 8'h00) begin n_bad++; $display("FAIL reset_data_lsb: got %h want 00", data_lsb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("reset: checked outputs after reset");
   endtask

   task automatic test_frame();
      logic [7:0] w;
      int strobes;
      w = 8'hA5;
      strobes = 0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b0, 1'b1, 1'b1, w[i]);
         if (dv_msb === 1'b1) strobes++;
      end
      n_cmp++; if (dv_msb !== 1'b1) begin n_bad++; $display("FAIL frame_latency: valid %b want 1", dv_msb); end
      n_cmp++; if (data_msb !== 8'hA5) begin n_bad++; $display("FAIL frame_data: got %h want a5", data_msb); end
      n_cmp++; if (cnt_msb !== 4'd1) begin n_bad++; $display("FAIL frame_cnt: got %0d want 1", cnt_msb); end
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (dv_msb !== 1'b0) begin n_bad++; $display("FAIL frame_strobe_width: valid %b want 0", dv_msb); end
      n_cmp++; if (strobes != 1) begin n_bad++; $display("FAIL frame_strobe_count: got %0d want 1", strobes); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (err_msb !== 1'b0) begin n_bad++; $display("FAIL frame_err: got %b want 0", err_msb); end
      $display("frame: word a5 data=%h cnt=%0d", data_msb, cnt_msb);
   endtask

   task automatic test_back_to_back();
      logic [15:0] w;
      logic [7:0]  got [2];
      int          nstr;
      int          bad_pos;
      w = 16'h3CC3;
      nstr = 0;
      bad_pos = 0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 15; i >= 0; i--) begin
         cycle(1'b0, 1'b1, 1'b1, w[i]);
         if (dv_msb === 1'b1) begin
            if (nstr < 2) got[nstr] = data_msb;
            nstr++;
            if (i != 8 && i != 0) bad_pos++;
         end
      end
      n_cmp++; if (nstr != 2) begin n_bad++; $display("FAIL b2b_strobes: got %0d want 2", nstr); end
      n_cmp++; if (bad_pos != 0) begin n_bad++; $display("FAIL b2b_strobe_pos: %0d misplaced want 0", bad_pos); end
      n_cmp++; if (got[0] !== 8'h3C) begin n_bad++; $display("FAIL b2b_word0: got %h want 3c", got[0]); end
      n_cmp++; if (got[1] !== 8'hC3) begin n_bad++; $display("FAIL b2b_word1: got %h want c3", got[1]); end
      n_cmp++; if (cnt_msb !== 4'd2) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 2", cnt_msb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("back_to_back: strobes=%0d last=%h cnt=%0d", nstr, data_msb, cnt_msb);
   endtask

   task automatic test_partial();
      int nstr;
      nstr = 0;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(1)));
         if (dv_msb === 1'b1) nstr++;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (nstr != 0) begin n_bad++; $display("FAIL partial_strobe: got %0d want 0", nstr); end
      n_cmp++; if (err_msb !== 1'b1) begin n_bad++; $display("FAIL partial_err: got %b want 1", err_msb); end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++; if (err_msb !== 1'b1) begin n_bad++; $display("FAIL partial_err_sticky: got %b want 1", err_msb); end
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (err_msb !== 1'b0) begin n_bad++; $display("FAIL partial_err_clear: got %b want 0", err_msb); end
      n_cmp++; if (cnt_msb !== 4'd0) begin n_bad++; $display("FAIL partial_cnt_clear: got %0d want 0", cnt_msb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("partial: err set then cleared, cnt=%0d", cnt_msb);
   endtask

   task automatic test_ignored();
      logic [7:0] w;
      logic [7:0] held;
      int nstr;
      int early;
      w = 8'h3C;
      held = m_word_msb;
      nstr = 0;
      early = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(1)));
         if (dv_msb === 1'b1) nstr++;
      end
      n_cmp++; if (nstr != 0) begin n_bad++; $display("FAIL ignored_strobe: got %0d want 0", nstr); end
      n_cmp++; if (data_msb !== held) begin n_bad++; $display("FAIL ignored_data: got %h want %h", data_msb, held); end
      // Pulse on the enable rising edge must be dropped.
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b0, 1'b1, 1'b1, w[i]);
         if (i != 0 && dv_msb === 1'b1) early++;
      end
      n_cmp++; if (early != 0) begin n_bad++; $display("FAIL ignored_rise_pulse: %0d early strobes want 0", early); end
      n_cmp++; if (dv_msb !== 1'b1) begin n_bad++; $display("FAIL ignored_final_strobe: got %b want 1", dv_msb); end
      n_cmp++; if (data_msb !== 8'h3C) begin n_bad++; $display("FAIL ignored_word: got %h want 3c", data_msb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("ignored: data=%h after rise-edge pulse dropped", data_msb);
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] w;
      w = 8'h5A;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (data_msb !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", data_msb); end
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b1, w[i]);
      n_cmp++; if (data_msb !== 8'h5A) begin n_bad++; $display("FAIL rstmid_word: got %h want 5a", data_msb); end
      n_cmp++; if (cnt_msb !== 4'd1) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 1", cnt_msb); end
      n_cmp++; if (err_msb !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b want 0", err_msb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (err_msb !== 1'b0) begin n_bad++; $display("FAIL rstmid_err_end: got %b want 0", err_msb); end
      $display("reset_mid_word: data=%h cnt=%0d", data_msb, cnt_msb);
   endtask

   task automatic test_wrap();
      logic [7:0] w;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 17; k++) begin
         w = 8'($urandom);
         for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b1, w[i]);
         n_cmp++; if (data_msb !== w) begin n_bad++; $display("FAIL wrap_word%0d: got %h want %h", k, data_msb, w); end
         n_cmp++; if (cnt_msb !== 4'((k + 1) % 16)) begin n_bad++; $display("FAIL wrap_cnt%0d: got %0d want %0d", k, cnt_msb, (k + 1) % 16); end
      end
      n_cmp++; if (cnt_msb !== 4'd1) begin n_bad++; $display("FAIL wrap_final: got %0d want 1", cnt_msb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("wrap: 17 words, cnt=%0d", cnt_msb);
   endtask

   task automatic test_lsb_first();
      logic [7:0] a;
      logic [7:0] b;
      a = 8'b1010_0101;   // serial order, first bit at index 7
      b = 8'b1100_0000;
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b1, a[i]);
      n_cmp++; if (data_lsb !== 8'hA5) begin n_bad++; $display("FAIL lsb_palindrome: got %h want a5", data_lsb); end
      n_cmp++; if (dv_lsb !== 1'b1) begin n_bad++; $display("FAIL lsb_strobe: got %b want 1", dv_lsb); end
      for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, 1'b1, b[i]);
      n_cmp++; if (data_lsb !== 8'h03) begin n_bad++; $display("FAIL lsb_word: got %h want 03", data_lsb); end
      n_cmp++; if (data_msb !== 8'hC0) begin n_bad++; $display("FAIL lsb_msb_view: got %h want c0", data_msb); end
      n_cmp++; if (cnt_lsb !== 4'd2) begin n_bad++; $display("FAIL lsb_cnt: got %0d want 2", cnt_lsb); end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      $display("lsb_first: lsb=%h msb=%h", data_lsb, data_msb);
   endtask

   task automatic test_random();
      logic r, e, s, m;
      int   bad_before;
      bad_before = n_bad;
      e = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         r = ($urandom_range(299) == 0);
         if ($urandom_range(39) == 0) e = ~e;
         s = ($urandom_range(2) != 0);
         m = 1'($urandom_range(1));
         cycle(r, e, s, m);
         n_cmp++; if (dv_msb !== m_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, dv_msb, m_valid); end
         n_cmp++; if (data_msb !== m_word_msb) begin n_bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, data_msb, m_word_msb); end
         n_cmp++; if (data_lsb !== m_word_lsb) begin n_bad++; $display("FAIL rnd_data_lsb c%0d: got %h want %h", c, data_lsb, m_word_lsb); end
         n_cmp++; if (cnt_msb !== 4'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, cnt_msb, m_cnt); end
         n_cmp++; if (err_msb !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_msb, m_err); end
         n_cmp++; if (dv_lsb !== m_valid || err_lsb !== m_err || cnt_lsb !== 4'(m_cnt)) begin
            n_bad++; $display("FAIL rnd_lsb_ctl c%0d: got v%b e%b c%0d want v%b e%b c%0d", c, dv_lsb, err_lsb, cnt_lsb, m_valid, m_err, m_cnt);
         end
      end
      $display("random: 4000 cycles, %0d new mismatches", n_bad - bad_before);
   endtask

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_partial();
      test_ignored();
      test_reset_mid_word();
      test_wrap();
      test_lsb_first();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_receiver.md
Name: data_receiver

Overview:
SPI slave-side receive path, the counterpart of the slave data transmitter.
- Samples the serial input on each upstream-detected SCL rising edge while the slave is enabled (chip-select asserted).
- Assembles DATA_WIDTH-bit words and presents each completed word with a one-cycle valid strobe.
- Flags frames that end mid-word.
- Sits between the SCL/CS edge-detection logic and the register/command decoder.

Parameters:
DATA_WIDTH, 8, bits per received word (≥2)
MSB_FIRST, 1, 1 = first received bit lands in data_o[DATA_WIDTH-1]; 0 = lands in data_o[0]
BYTE_CNT_WIDTH, 4, width of per-frame word counter

Ports:
clk_i  input  1  system clock, all logic on posedge
reset_i  input  1  synchronous, active-high reset
en_i  input  1  slave enable (active-high CS, already synchronised upstream)
scl_pos_edge_detected_i  input  1  one-cycle pulse per SCL rising edge
mosi_i  input  1  serial data from master
data_o  output  DATA_WIDTH  last completed word
data_valid_o  output  1  one-cycle strobe, data_o updated this cycle
byte_cnt_o  output  BYTE_CNT_WIDTH  words completed in current frame
frame_error_o  output  1  sticky: frame ended with a partial word

Behaviour:
- Reset values: data_o=0, data_valid_o=0, byte_cnt_o=0, frame_error_o=0. Internal state after reset: bit counter=DATA_WIDTH, shift register=0, en_q=0.
- Reset mid-word discards the partial word. No frame error is raised for it.
- en_q is a registered copy of en_i.
- Rising edge (en_i=1, en_q=0): byte_cnt_o<=0, frame_error_o<=0, bit counter<=DATA_WIDTH, shift register<=0.
- Falling edge (en_i=0, en_q=1): if bit counter != DATA_WIDTH, frame_error_o<=1. Otherwise frame_error_o is unchanged.
- While en_i=0:
  - bit counter is held at DATA_WIDTH; shift register is held at 0.
  - data_valid_o=0.
  - scl pulses are ignored.
  - data_o, byte_cnt_o and frame_error_o hold their values.
- Sampling, on a cycle with en_i=1 and scl_pos_edge_detected_i=1 (the sample is mosi_s, the possibly-synchronised mosi_i):
  - MSB_FIRST=1: shift <= {shift[W-2:0], mosi_s}.
  - MSB_FIRST=0: shift <= {mosi_s, shift[W-1:1]}.
  - bit counter decrements by 1.
- Completion: when the counter is 1 on a sampling cycle, the next clock edge does all of the following:
  - data_o <= completed word, including the current bit.
  - data_valid_o <= 1 for exactly one cycle.
  - byte_cnt_o <= byte_cnt_o+1, wrapping modulo 2^BYTE_CNT_WIDTH.
  - bit counter <= DATA_WIDTH.
- Latency: data_valid_o asserts 1 clk after the final scl pulse.
- Back-to-back words need no idle cycles. The next word's first sample may arrive on the cycle data_valid_o is high.
- Same-cycle en_i fall and scl pulse: en_i low wins. The bit is dropped and the frame-error check uses the pre-pulse counter.
- Same-cycle en_i rise and scl pulse: the pulse is ignored; the first sample is taken no earlier than the cycle after the rising edge.
- frame_error_o is cleared only by reset or the next en_i rising edge.
- No backpressure. A consumer that misses data_valid_o loses the word.

Optional Feature:
Macro SPI_RX_MOSI_SYNC_EN.
- Defined: mosi_i passes through a 2-flop synchroniser. mosi_s is the second flop's output. The upstream SCL edge detector applies matching 2-cycle alignment.
- Undefined: mosi_s = mosi_i directly with zero added latency. Use this only when mosi_i is already synchronous to clk_i.
- All other behaviour is identical in both builds.

Test Plan:
- Frame: en_i=1, 8 scl pulses carrying 1,0,1,0,0,1,0,1 (MSB_FIRST=1) -> data_o=0xA5, data_valid_o high exactly 1 cycle after 8th pulse, byte_cnt_o=1; en_i drop -> frame_error_o stays 0.
- Back-to-back: 16 pulses for 0x3C then 0xC3, no gaps -> two single-cycle strobes, data_o 0x3C then 0xC3, byte_cnt_o=2.
- Partial frame: 5 pulses, then en_i=0 -> no strobe, frame_error_o=1 held; next en_i rise -> frame_error_o=0, byte_cnt_o=0.
- Ignored pulses: 8 pulses with en_i=0 -> no strobe, data_o unchanged. Then en_i rise with a pulse on the same cycle -> that bit dropped; a full byte needs 8 further pulses.
- Reset mid-word: 4 pulses, reset_i for 1 cycle, then 8 pulses of 0x5A -> data_o=0x5A, frame_error_o=0, byte_cnt_o=1.
- Wrap and LSB-first: 17 words in one frame -> byte_cnt_o reads 1 after the 17th. MSB_FIRST=0 with serial 1,0,1,0,0,1,0,1 -> data_o=0xA5 reversed = 0xA5 (palindrome check); also 1,1,0,0,0,0,0,0 -> data_o=0x03.
